pp_gen_8x8: RTL and testbench

//  Sequential partial-product generator for the 8x8 multiplier datapath; sits directly upstream of the
//  8-row reduction adder chain and drives its sixteen-bit rows P0..P7.

---
 rtl/pp_gen_pkg.sv | 16 +
 rtl/pp_row_gen.sv | 37 +++
 rtl/pp_gen_8x8.sv | 113 +++++++++++
 tb/tb_pp_gen_8x8.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pp_gen_pkg.sv
// Shared constants and types for the 8x8 partial-product generator.
// Build option: define PP_SIGNED_EN for two's-complement operands (see pp_row_gen).
package pp_gen_pkg;

  localparam int N  = 8;
  localparam int PW = 2 * N;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [2:0] row_idx_t;

endpackage

// File: rtl/pp_row_gen.sv
// Combinational generator for one partial-product row selected by a multiplier bit.
// PP_SIGNED_EN: sign-extend a and negate the top row (two's-complement weight of b[7]).
module pp_row_gen
  import pp_gen_pkg::*;
(
  input  logic [N-1:0]  a,
  input  logic          b_bit,
  input  row_idx_t      idx,
  output logic [PW-1:0] row
);

  logic [PW-1:0] shifted_s;

  // Row value: shifted multiplicand gated by the multiplier bit
  always_comb begin
    row = {PW{1'b0}};
`ifdef PP_SIGNED_EN
    shifted_s = {{N{a[N-1]}}, a} << idx;
    if (!b_bit) begin
      row = {PW{1'b0}};
    end else if (idx == 3'd7) begin
      // b[7] carries weight -2^7 in two's complement
      row = 16'h0000 - shifted_s;
    end else begin
      row = shifted_s;
    end
`else
    shifted_s = {8'h00, a} << idx;
    if (b_bit) begin
      row = shifted_s;
    end else begin
      row = {PW{1'b0}};
    end
`endif
  end

endmodule

// File: rtl/pp_gen_8x8.sv
// Sequential 8x8 partial-product generator: one row per clock, bank held until consumed.
// Build option: PP_SIGNED_EN selects two's-complement operands.
module pp_gen_8x8
  import pp_gen_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] p0,
  output logic [PW-1:0] p1,
  output logic [PW-1:0] p2,
  output logic [PW-1:0] p3,
  output logic [PW-1:0] p4,
  output logic [PW-1:0] p5,
  output logic [PW-1:0] p6,
  output logic [PW-1:0] p7,
  output logic          busy
);

  state_t        state_r, next_state_s;
  row_idx_t      cnt_r;
  logic [N-1:0]  a_r, b_r;
  logic [PW-1:0] rows_r [N];
  logic [PW-1:0] row_s;
  logic          out_valid_r, busy_r;
  logic          in_ready_s, accept_s;

  pp_row_gen u_row_gen (
    .a     (a_r),
    .b_bit (b_r[cnt_r]),
    .idx   (cnt_r),
    .row   (row_s)
  );

  // Next-state and handshake decode; DONE accepts a new pair only alongside a transfer
  always_comb begin
    next_state_s = state_r;
    in_ready_s   = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        if (in_valid) next_state_s = GEN;
        else          next_state_s = IDLE;
      end
      GEN: begin
        if (cnt_r == 3'd7) next_state_s = DONE;
        else               next_state_s = GEN;
      end
      DONE: begin
        in_ready_s = out_ready;
        if (out_ready) begin
          if (in_valid) next_state_s = GEN;
          else          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
    accept_s = in_valid && in_ready_s;
  end

  // State register with status flags registered from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      out_valid_r <= (next_state_s == DONE);
      busy_r      <= (next_state_s == GEN);
    end
  end

  // Operand capture, row counter and row bank
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= 3'd0;
      a_r   <= 8'h00;
      b_r   <= 8'h00;
      for (int i = 0; i < N; i++) rows_r[i] <= {PW{1'b0}};
    end else if (accept_s) begin
      cnt_r <= 3'd0;
      a_r   <= a;
      b_r   <= b;
      for (int i = 0; i < N; i++) rows_r[i] <= {PW{1'b0}};
    end else if (state_r == GEN) begin
      rows_r[cnt_r] <= row_s;
      cnt_r         <= cnt_r + 3'd1;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign p0 = rows_r[0];
  assign p1 = rows_r[1];
  assign p2 = rows_r[2];
  assign p3 = rows_r[3];
  assign p4 = rows_r[4];
  assign p5 = rows_r[5];
  assign p6 = rows_r[6];
  assign p7 = rows_r[7];

endmodule

// File: tb/tb_pp_gen_8x8.sv
// Directed self-checking bench for pp_gen_8x8; expectations follow PP_SIGNED_EN when defined.
module tb_pp_gen_8x8;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, in_ready, out_valid, busy;
  logic [7:0]  a, b;
  logic [15:0] p0, p1, p2, p3, p4, p5, p6, p7;
  logic [15:0] p_obs [8];

  int total  = 0;
  int passes = 0;

  always #5 clk = ~clk;

  pp_gen_8x8 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7),
    .busy(busy)
  );

  assign p_obs[0] = p0; assign p_obs[1] = p1; assign p_obs[2] = p2; assign p_obs[3] = p3;
  assign p_obs[4] = p4; assign p_obs[5] = p5; assign p_obs[6] = p6; assign p_obs[7] = p7;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic check_rows(input string tag, input logic [15:0] exp [8], input logic [15:0] exp_sum);
    logic [15:0] sum;
    sum = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_p%0d", tag, i), p_obs[i], exp[i]);
      sum = sum + p_obs[i];
    end
    check({tag, "_sum"}, sum, exp_sum);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic status(input string tag, input logic v, input logic r, input logic bz);
    check({tag, "_out_valid"}, {15'h0000, out_valid}, {15'h0000, v});
    check({tag, "_in_ready"},  {15'h0000, in_ready},  {15'h0000, r});
    check({tag, "_busy"},      {15'h0000, busy},      {15'h0000, bz});
  endtask

  initial begin
    int lat;
    logic [15:0] zero_rows [8];
    logic [15:0] exp_0d0b  [8];
    logic [15:0] exp_ffff  [8];
    logic [15:0] exp_0203  [8];
    logic [15:0] exp_1281  [8];
    logic [15:0] sum_ffff, sum_1281;

    zero_rows = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    exp_0d0b  = '{16'h000D, 16'h001A, 16'h0000, 16'h0068, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    exp_0203  = '{16'h0002, 16'h0004, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
`ifdef PP_SIGNED_EN
    exp_ffff  = '{16'hFFFF, 16'hFFFE, 16'hFFFC, 16'hFFF8, 16'hFFF0, 16'hFFE0, 16'hFFC0, 16'h0080};
    sum_ffff  = 16'h0001;
    exp_1281  = '{16'h0012, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hF700};
    sum_1281  = 16'hF712;
`else
    exp_ffff  = '{16'h00FF, 16'h01FE, 16'h03FC, 16'h07F8, 16'h0FF0, 16'h1FE0, 16'h3FC0, 16'h7F80};
    sum_ffff  = 16'hFE01;
    exp_1281  = '{16'h0012, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0900};
    sum_1281  = 16'h0912;
`endif

    // Reset
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00;
    tick(); tick();
    status("reset", 1'b0, 1'b1, 1'b0);
    check_rows("reset", zero_rows, 16'h0000);
    rst_n = 1'b1;
    tick();

    // 0x0D * 0x0B
    a = 8'h0D; b = 8'h0B; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = 8'hAA; b = 8'h55;
    status("gen1", 1'b0, 1'b0, 1'b1);
    wait_valid(lat);
    check("lat1", lat[15:0], 16'd8);
    check_rows("r0d0b", exp_0d0b, 16'h008F);
    out_ready = 1'b1;
    tick();
    status("xfer1", 1'b0, 1'b1, 1'b0);
    out_ready = 1'b0;
    tick();

    // 0xFF * 0xFF, then backpressure
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    check("lat2", lat[15:0], 16'd8);
    check_rows("rffff", exp_ffff, sum_ffff);
    in_valid = 1'b1; a = 8'h33; b = 8'h77;
    for (int k = 0; k < 5; k++) begin
      tick();
      status($sformatf("bp%0d", k), 1'b1, 1'b0, 1'b0);
    end
    check_rows("bp_hold", exp_ffff, sum_ffff);

    // Back-to-back transfer plus new pair on the same edge
    a = 8'h02; b = 8'h03; out_ready = 1'b1; in_valid = 1'b1;
    #1;
    check("b2b_in_ready", {15'h0000, in_ready}, 16'h0001);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    status("b2b_accept", 1'b0, 1'b0, 1'b1);
    wait_valid(lat);
    check("lat3", lat[15:0], 16'd8);
    check_rows("r0203", exp_0203, 16'h0006);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset during GEN cycle 4
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    check("pre_rst_p0", p0, exp_ffff[0]);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    status("mid_rst", 1'b0, 1'b1, 1'b0);
    check_rows("mid_rst", zero_rows, 16'h0000);
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("no_valid%0d", k), {15'h0000, out_valid}, 16'h0000);
    end

    // Next pair after abort
    a = 8'h12; b = 8'h81; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    check("lat4", lat[15:0], 16'd8);
    check_rows("r1281", exp_1281, sum_1281);
    out_ready = 1'b1;
    tick();
    status("xfer4", 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
